// File: rtl/lcu_stream_feeder.sv
// lcu_stream_feeder: walks a 128x128 frame LCU by LCU, fetches each LCU's
// SAO parameter word, and streams the LCU's pixels through a small skid FIFO
// to the SAO stage under its busy back-pressure.
module lcu_stream_feeder #(
    parameter int IMG_W      = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  lcu_size_cfg,
    output logic        img_rd,
    output logic [13:0] img_addr,
    input  logic [7:0]  img_q,
    output logic        par_rd,
    output logic [5:0]  par_addr,
    input  logic [23:0] par_q,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [1:0]  sao_type,
    output logic [4:0]  sao_band_pos,
    output logic        sao_eo_class,
    output logic [15:0] sao_offset,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic [1:0]  lcu_size,
    input  logic        busy,
    output logic        done
);

    localparam int ROW_SHIFT = $clog2(IMG_W);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] ISSUE_LIMIT = CNT_W'(FIFO_DEPTH - 2);

    typedef enum logic [2:0] {
        IDLE,
        PFETCH,
        PLATCH,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]  sizeCfg_q;
    logic [2:0]  lcuX_q, lcuY_q;
    logic [5:0]  px_q, py_q;
    logic        rdPend_q;
    logic [7:0]  fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] occ_q;

    logic [1:0]  saoType_q;
    logic [4:0]  saoBand_q;
    logic        saoEo_q;
    logic [15:0] saoOffset_q;
    logic [2:0]  lcuXOut_q, lcuYOut_q;
    logic [1:0]  lcuSizeOut_q;

    logic [5:0]  sMax;
    logic [2:0]  nMax;
    logic [2:0]  lcuShift;
    logic [6:0]  rowPix, colPix;
    logic        accept, drainDone, lastRead, lastLcu, issueOk;

    // Decode the latched size code into pixel/LCU limits and the parameter index
    always_comb begin
        sMax     = 6'd63;
        nMax     = 3'd1;
        lcuShift = 3'd6;
        par_addr = {4'b0, lcuY_q[0], lcuX_q[0]};
        case (sizeCfg_q)
            2'd0: begin
                sMax     = 6'd15;
                nMax     = 3'd7;
                lcuShift = 3'd4;
                par_addr = {lcuY_q, lcuX_q};
            end
            2'd1: begin
                sMax     = 6'd31;
                nMax     = 3'd3;
                lcuShift = 3'd5;
                par_addr = {2'b0, lcuY_q[1:0], lcuX_q[1:0]};
            end
            default: ;
        endcase
    end

    assign rowPix    = (7'(lcuY_q) << lcuShift) + 7'(py_q);
    assign colPix    = (7'(lcuX_q) << lcuShift) + 7'(px_q);
    assign img_addr  = (14'(rowPix) << ROW_SHIFT) | 14'(colPix);

    assign in_en     = (occ_q != '0);
    assign din       = fifoMem_q[rdPtr_q];
    assign accept    = in_en && !busy;
    assign lastRead  = (px_q == sMax) && (py_q == sMax);
    assign lastLcu   = (lcuX_q == nMax) && (lcuY_q == nMax);
    assign issueOk   = (occ_q + CNT_W'(rdPend_q)) <= ISSUE_LIMIT;
    // Counting the beat accepted this very edge lets the FSM leave DRAIN without a spare cycle
    assign drainDone = !rdPend_q && ((occ_q == '0) || ((occ_q == CNT_W'(1)) && accept));

    assign sao_type     = saoType_q;
    assign sao_band_pos = saoBand_q;
    assign sao_eo_class = saoEo_q;
    assign sao_offset   = saoOffset_q;
    assign lcu_x        = lcuXOut_q;
    assign lcu_y        = lcuYOut_q;
    assign lcu_size     = lcuSizeOut_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic for the per-LCU fetch/stream/drain sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PFETCH;
            PFETCH:  state_d = PLATCH;
            PLATCH:  state_d = STREAM;
            STREAM:  if (img_rd && lastRead) state_d = DRAIN;
            DRAIN:   if (drainDone) state_d = lastLcu ? DONE : PFETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes: reads are throttled so occupancy plus in-flight data never outruns the FIFO
    always_comb begin
        img_rd = 1'b0;
        par_rd = 1'b0;
        done   = 1'b0;
        case (state_q)
            PFETCH:  par_rd = 1'b1;
            STREAM:  img_rd = issueOk;
            DONE:    done   = 1'b1;
            default: ;
        endcase
    end

    // Frame position: size latch, LCU coordinates and pixel counters inside the LCU
    always_ff @(posedge clk) begin
        if (reset) begin
            sizeCfg_q <= '0;
            lcuX_q    <= '0;
            lcuY_q    <= '0;
            px_q      <= '0;
            py_q      <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                sizeCfg_q <= lcu_size_cfg;
                lcuX_q    <= '0;
                lcuY_q    <= '0;
                px_q      <= '0;
                py_q      <= '0;
            end
            if (state_q == STREAM && img_rd) begin
                if (px_q == sMax) begin
                    px_q <= '0;
                    py_q <= (py_q == sMax) ? 6'd0 : py_q + 6'd1;
                end else begin
                    px_q <= px_q + 6'd1;
                end
            end
            if (state_q == DRAIN && drainDone && !lastLcu) begin
                if (lcuX_q == nMax) begin
                    lcuX_q <= '0;
                    lcuY_q <= lcuY_q + 3'd1;
                end else begin
                    lcuX_q <= lcuX_q + 3'd1;
                end
            end
        end
    end

    // Sideband registers only move in PLATCH, when no beat is waiting in the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            saoType_q    <= '0;
            saoBand_q    <= '0;
            saoEo_q      <= 1'b0;
            saoOffset_q  <= '0;
            lcuXOut_q    <= '0;
            lcuYOut_q    <= '0;
            lcuSizeOut_q <= '0;
        end else if (state_q == PLATCH) begin
            saoType_q    <= par_q[23:22];
            saoBand_q    <= par_q[21:17];
            saoEo_q      <= par_q[16];
            saoOffset_q  <= par_q[15:0];
            lcuXOut_q    <= lcuX_q;
            lcuYOut_q    <= lcuY_q;
            lcuSizeOut_q <= sizeCfg_q;
        end
    end

    // Skid FIFO: image data lands one cycle after its read strobe, head leaves on each accepted beat
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPend_q <= 1'b0;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            occ_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifoMem_q[i] <= '0;
        end else begin
            rdPend_q <= img_rd;
            if (rdPend_q) begin
                fifoMem_q[wrPtr_q] <= img_q;
                wrPtr_q            <= wrPtr_q + PTR_W'(1);
            end
            if (accept) rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({rdPend_q, accept})
                2'b10:   occ_q <= occ_q + CNT_W'(1);
                2'b01:   occ_q <= occ_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcu_stream_feeder.sv
// Bench for lcu_stream_feeder: SRAM models, a scoreboard of expected beats and
// parameter fetches, and directed frames covering sizes, back-pressure and reset.
module tb_lcu_stream_feeder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  lcu_size_cfg;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_q;
    logic        par_rd;
    logic [5:0]  par_addr;
    logic [23:0] par_q;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  sao_type;
    logic [4:0]  sao_band_pos;
    logic        sao_eo_class;
    logic [15:0] sao_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        busy;
    logic        done;

    lcu_stream_feeder #(.IMG_W(128), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .lcu_size_cfg(lcu_size_cfg),
        .img_rd(img_rd), .img_addr(img_addr), .img_q(img_q),
        .par_rd(par_rd), .par_addr(par_addr), .par_q(par_q),
        .in_en(in_en), .din(din), .sao_type(sao_type), .sao_band_pos(sao_band_pos),
        .sao_eo_class(sao_eo_class), .sao_offset(sao_offset),
        .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
        .busy(busy), .done(done)
    );

    logic [7:0]  imgMem [16384];
    logic [23:0] parMem [64];
    logic [63:0] expQ [$];
    logic [5:0]  parQ [$];

    int testsRun = 0;
    int failCnt  = 0;
    int edgeCnt  = 0;
    int frameId  = 0;
    int startEdge = 0;
    bit randBusy = 1'b0;

    int beatCnt, doneCnt, doneEdge, lastAcceptEdge, firstInEnEdge, firstParRdEdge;
    logic [63:0] capFirst, capLcu1;

    logic [63:0] curBeat;
    logic [63:0] outVec;
    assign curBeat = {24'b0, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
                      lcu_x, lcu_y, lcu_size};
    assign outVec  = {img_rd, img_addr, par_rd, par_addr, in_en, din, sao_type,
                      sao_band_pos, sao_eo_class, sao_offset, lcu_x, lcu_y, lcu_size, done};

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so latencies can be measured in cycles
    initial begin
        forever begin
            @(posedge clk);
            edgeCnt++;
        end
    end

    // Frame and parameter SRAMs: registered read data one cycle after the strobe
    always @(posedge clk) begin
        if (img_rd) img_q <= imgMem[img_addr];
        if (par_rd) par_q <= parMem[par_addr];
    end

    // SAO back-pressure: idle, or a coin toss each cycle when the random mode is on
    initial begin
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            busy = randBusy && ($urandom_range(0, 1) == 1);
        end
    end

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // A check that could not be made at all (missing event, extra beat) counts as a failure
    task automatic reportFail(input string name, input string what);
        testsRun++;
        failCnt++;
        $display("[TB] FAIL %s: got %s, expected none", name, what);
    endtask

    // Monitor: pops the scoreboard on every accepted beat and parameter fetch, and
    // watches hold-under-busy, LCU bubbles and the done pulse
    initial begin
        int seenFrame;
        bit prevInEn;
        bit stallValid;
        logic [63:0] stallBeat;
        seenFrame = -1;
        prevInEn = 1'b0;
        stallValid = 1'b0;
        stallBeat = '0;
        forever begin
            @(negedge clk);
            if (frameId != seenFrame) begin
                seenFrame = frameId;
                beatCnt = 0; doneCnt = 0; doneEdge = -1; lastAcceptEdge = -1;
                firstInEnEdge = -1; firstParRdEdge = -1;
                capFirst = '0; capLcu1 = '0;
                prevInEn = 1'b0; stallValid = 1'b0;
            end
            if (reset) begin
                prevInEn = 1'b0;
                stallValid = 1'b0;
            end else begin
                if (stallValid) checkOutput("holdWhileBusy", curBeat, stallBeat);
                stallValid = in_en && busy;
                stallBeat = curBeat;
                if (in_en && !prevInEn) begin
                    if (firstInEnEdge < 0) firstInEnEdge = edgeCnt;
                    else if (!randBusy && lastAcceptEdge >= 0)
                        checkOutput("lcuBubble", 64'(edgeCnt - lastAcceptEdge), 64'd4);
                end
                prevInEn = in_en;
                if (par_rd) begin
                    if (firstParRdEdge < 0) firstParRdEdge = edgeCnt;
                    if (parQ.size() == 0) reportFail("parFetch", "unexpected par_rd");
                    else checkOutput("parAddr", 64'(par_addr), 64'(parQ.pop_front()));
                end
                if (done) begin
                    doneCnt++;
                    doneEdge = edgeCnt;
                end
                if (in_en && !busy) begin
                    if (beatCnt == 0) capFirst = curBeat;
                    if (beatCnt == 1024) capLcu1 = curBeat;
                    if (expQ.size() == 0) reportFail("beat", "unexpected beat");
                    else checkOutput("beat", curBeat, expQ.pop_front());
                    beatCnt++;
                    lastAcceptEdge = edgeCnt + 1;
                end
            end
        end
    end

    // Fill the frame SRAM: 0 = low-byte ramp, otherwise a pattern that also encodes the high address bits
    task automatic loadImage(input int pattern);
        for (int a = 0; a < 16384; a++)
            imgMem[a] = (pattern == 0) ? 8'(a) : 8'((a & 255) ^ ((a >> 8) * 37));
    endtask

    // Golden LCU scan: raster LCUs, raster pixels inside, each with its LCU's parameter word
    task automatic prepFrame(input int cfg);
        int s, n, k, addr;
        s = (cfg == 0) ? 16 : (cfg == 1) ? 32 : 64;
        n = 128 / s;
        frameId++;
        expQ.delete();
        parQ.delete();
        for (int ly = 0; ly < n; ly++) begin
            for (int lx = 0; lx < n; lx++) begin
                k = ly * n + lx;
                parQ.push_back(6'(k));
                for (int py = 0; py < s; py++) begin
                    for (int px = 0; px < s; px++) begin
                        addr = (ly * s + py) * 128 + lx * s + px;
                        expQ.push_back({24'b0, imgMem[addr], parMem[k], 3'(lx), 3'(ly), 2'(cfg)});
                    end
                end
            end
        end
    endtask

    // One-cycle start; the size input is then moved so only the start-edge value may matter
    task automatic startFrame(input int cfg);
        @(posedge clk);
        #1;
        lcu_size_cfg = 2'(cfg);
        start = 1'b1;
        startEdge = edgeCnt + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lcu_size_cfg = 2'(cfg + 1);
    endtask

    task automatic waitBeats(input int target, input int limit);
        int guard;
        guard = 0;
        while (beatCnt < target && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        if (beatCnt < target) reportFail("beatWait", "timeout");
    endtask

    task automatic waitDone(input int limit);
        int guard;
        guard = 0;
        while (doneCnt == 0 && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        if (doneCnt == 0) reportFail("doneWait", "timeout");
    endtask

    // Run one whole frame and check its totals and latencies
    task automatic applyStimulus(input int cfg, input int pattern, input bit busyOn, input bit glitch);
        loadImage(pattern);
        randBusy = busyOn;
        prepFrame(cfg);
        startFrame(cfg);
        if (glitch) begin
            waitBeats(100, 2000);
            @(posedge clk);
            #1;
            start = 1'b1;
            lcu_size_cfg = 2'd0;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        waitDone(busyOn ? 60000 : 40000);
        repeat (10) @(negedge clk);
        randBusy = 1'b0;
        checkOutput("beatCount", 64'(beatCnt), 64'd16384);
        checkOutput("donePulses", 64'(doneCnt), 64'd1);
        checkOutput("leftoverBeats", 64'(expQ.size()), 64'd0);
        checkOutput("leftoverParFetches", 64'(parQ.size()), 64'd0);
        checkOutput("doneLatency", 64'(doneEdge - lastAcceptEdge), 64'd0);
        checkOutput("parRdLatency", 64'(firstParRdEdge - startEdge), 64'd0);
        checkOutput("firstBeatLatency", 64'(firstInEnEdge - startEdge), 64'd4);
        if (cfg == 1 && pattern == 0) begin
            checkOutput("firstBeatFields", capFirst,
                        {24'b0, 8'h00, 2'd3, 5'd1, 1'b0, 16'hF00F, 3'd0, 3'd0, 2'd1});
            checkOutput("lcu1FirstBeat", capLcu1,
                        {24'b0, 8'h20, 2'd1, 5'd0, 1'b0, 16'h0000, 3'd1, 3'd0, 2'd1});
        end
    endtask

    // Main sequence: reset values, reset mid-LCU 3, then full frames at each size
    initial begin
        reset = 1'b1;
        start = 1'b0;
        lcu_size_cfg = 2'd0;
        parMem[0] = 24'hC2F00F;
        parMem[1] = 24'h400000;
        for (int k = 2; k < 64; k++)
            parMem[k] = {2'(k), 5'(k * 7), 1'(k >> 1), 16'(16'hA000 + k * 16'h0111)};
        loadImage(0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetValues", outVec, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        prepFrame(0);
        startFrame(0);
        waitBeats(3 * 256 + 77, 5000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midFrameResetValues", outVec, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        parQ.delete();
        frameId++;

        applyStimulus(1, 0, 1'b0, 1'b1);
        applyStimulus(0, 0, 1'b0, 1'b0);
        applyStimulus(2, 1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
        $finish;
    end

endmodule
